// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_m_state_t;

    // Register-slave map offsets
    localparam logic [7:0] REG_GROUP   = 8'h00;
    localparam logic [7:0] REG_DATE    = 8'h04;
    localparam logic [7:0] REG_SURNAME = 8'h08;
    localparam logic [7:0] REG_NAME    = 8'h0C;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Width able to hold 0..limit; a disabled (zero) limit still needs one bit
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - saturating watchdog counter with clear/enable and limit-hit flag
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_hit
);

    localparam int CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_V  = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (LIMIT > 0) && (r_count != LIMIT_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the increment that makes the count reach LIMIT
    assign o_hit = (LIMIT > 0) && i_en && (r_count == LAST_V);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-beat host command to APB3 transfer requester with watchdog
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    apb_m_state_t r_state;

    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic w_accept;
    logic w_wait;
    logic w_timeout;

    assign w_accept = (r_state == IDLE) && cmd_valid && r_cmd_ready;
    assign w_wait   = (r_state == ACCESS) && !pready;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk   (pclk),
        .i_rst   (preset),
        .i_clear (w_accept),
        .i_en    (w_wait),
        .o_hit   (w_timeout)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_state     <= SETUP;
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_write ? cmd_wdata : '0;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    // pready outranks a watchdog hit in the same cycle
                    if (pready || w_timeout) begin
                        r_state       <= IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_pwrite      <= 1'b0;
                        r_paddr       <= '0;
                        r_pwdata      <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= (pready && !r_pwrite) ? prdata : '0;
                        r_rsp_err     <= pready ? pslverr : 1'b1;
                        r_rsp_timeout <= !pready;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
